mem_access: RTL and testbench

Memory-access stage of the RV64 pipeline, between the execute-stage register and `mem_wb`. Turns load/store micro-ops into single 64-bit-word transactions on the data bus (req/gnt then rvalid), builds byte strobes and replicated write data, and sign/zero-extends load data. Stalls the pipeline through `hold_o` while a transaction is in flight. Non-memory ops pass through combinationally.

---
 rtl/mem_access.sv | 193 +++++++++++++++++++
 tb/tb_mem_access.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: RV64 memory-access stage. Turns load/store ops into single
// 64-bit-word data-bus transactions (req/gnt, then rvalid), builds byte
// strobes and replicated store data, and extends load data. Stalls upstream
// through hold_o while a transaction is in flight.
// Build option MEM_MISALIGN_TRAP_EN: misaligned H/W/D ops raise exc_o and skip
// the bus; when undefined, the low offset bits are masked to natural alignment.

package mem_access_pkg;
  localparam int unsigned DATA_LEN = 64;
  localparam int unsigned REG_IDX  = 5;
  localparam int unsigned STRB_W   = DATA_LEN / 8;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                rmem_i,
  input  logic                wmem_i,
  input  logic                wb_i,
  input  logic [2:0]          funct3_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [DATA_LEN-1:0] result_i,
  input  logic [REG_IDX-1:0]  rd_idx_i,
  input  logic                hold_i,
  output logic [DATA_LEN-1:0] raddr_o,
  output logic [DATA_LEN-1:0] result_o,
  output logic [REG_IDX-1:0]  rd_idx_o,
  output logic                wb_o,
  output logic                rmem_o,
  output logic                wmem_o,
  output logic                hold_o,
  output logic                exc_o,
  output logic                dbus_req_o,
  output logic                dbus_we_o,
  output logic [DATA_LEN-1:0] dbus_addr_o,
  output logic [DATA_LEN-1:0] dbus_wdata_o,
  output logic [STRB_W-1:0]   dbus_wstrb_o,
  input  logic                dbus_gnt_i,
  input  logic                dbus_rvalid_i,
  input  logic [DATA_LEN-1:0] dbus_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]          funct3_q;
  logic                we_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic                mem_op_c, misalign_c, start_c, trap_c;
  logic [2:0]          st_off_c, ld_off_c;
  logic [STRB_W-1:0]   st_strb_c;
  logic [DATA_LEN-1:0] st_wdata_c, ld_shift_c, ld_data_c;

  // Offset bits that survive natural alignment for a given access size
  function automatic logic [2:0] off_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b111;
      2'b01:   return 3'b110;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign mem_op_c = valid_i & (rmem_i | wmem_i);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = |(addr_i[2:0] & ~off_mask(funct3_i[1:0]));
`else
  assign misalign_c = 1'b0;
`endif
  assign start_c = (state_q == S_IDLE) & mem_op_c & ~misalign_c;
  assign trap_c  = (state_q == S_IDLE) & mem_op_c & misalign_c;

  // Store lane placement computed from the incoming op
  always_comb begin
    st_off_c   = addr_i[2:0] & off_mask(funct3_i[1:0]);
    st_strb_c  = '0;
    st_wdata_c = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_strb_c  = STRB_W'(8'h01 << st_off_c);
        st_wdata_c = {8{wdata_i[7:0]}};
      end
      2'b01: begin
        st_strb_c  = STRB_W'(8'h03 << st_off_c);
        st_wdata_c = {4{wdata_i[15:0]}};
      end
      2'b10: begin
        st_strb_c  = STRB_W'(8'h0F << st_off_c);
        st_wdata_c = {2{wdata_i[31:0]}};
      end
      default: st_strb_c = 8'hFF;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched op
  always_comb begin
    ld_off_c   = addr_q[2:0] & off_mask(funct3_q[1:0]);
    ld_shift_c = dbus_rdata_i >> {ld_off_c, 3'b000};
    case (funct3_q)
      3'b000:  ld_data_c = {{56{ld_shift_c[7]}},  ld_shift_c[7:0]};
      3'b001:  ld_data_c = {{48{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'b010:  ld_data_c = {{32{ld_shift_c[31]}}, ld_shift_c[31:0]};
      3'b100:  ld_data_c = {56'd0, ld_shift_c[7:0]};
      3'b101:  ld_data_c = {48'd0, ld_shift_c[15:0]};
      3'b110:  ld_data_c = {32'd0, ld_shift_c[31:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c)       state_d = S_REQ;
      S_REQ:   if (dbus_gnt_i)    state_d = S_WAIT;
      S_WAIT:  if (dbus_rvalid_i) state_d = S_DONE;
      S_DONE:  if (!hold_i)       state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall, bus request, result mux, trap handling
  always_comb begin
    hold_o     = 1'b0;
    dbus_req_o = 1'b0;
    result_o   = result_i;
    exc_o      = 1'b0;
    wb_o       = wb_i;
    rmem_o     = rmem_i;
    wmem_o     = wmem_i;
    case (state_q)
      S_IDLE:  hold_o = start_c;
      S_REQ: begin
        hold_o     = 1'b1;
        dbus_req_o = 1'b1;
      end
      S_WAIT:  hold_o = 1'b1;
      S_DONE:  result_o = rdata_q;
      default: ;
    endcase
    if (trap_c) begin
      exc_o  = 1'b1;
      wb_o   = 1'b0;
      rmem_o = 1'b0;
      wmem_o = 1'b0;
    end
    if (!rst) begin
      hold_o = 1'b0;
      exc_o  = 1'b0;
    end
  end

  // Op latch on acceptance and load-data capture on rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (start_c) begin
        addr_q   <= addr_i;
        funct3_q <= funct3_i;
        wdata_q  <= st_wdata_c;
        wstrb_q  <= wmem_i ? st_strb_c : '0;
        we_q     <= wmem_i;
      end
      if ((state_q == S_WAIT) && dbus_rvalid_i && !we_q) rdata_q <= ld_data_c;
    end
  end

  assign raddr_o      = addr_i;
  assign rd_idx_o     = rd_idx_i;
  assign dbus_addr_o  = {addr_q[DATA_LEN-1:3], 3'b000};
  assign dbus_we_o    = we_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a
// byte-level reference model of lane placement, extension and cycle counts.
module tb_mem_access;

  logic        clk, rst;
  logic        valid_i, rmem_i, wmem_i, wb_i, hold_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i, wdata_i, result_i;
  logic [4:0]  rd_idx_i;
  logic [63:0] raddr_o, result_o;
  logic [4:0]  rd_idx_o;
  logic        wb_o, rmem_o, wmem_o, hold_o, exc_o;
  logic        dbus_req_o, dbus_we_o;
  logic [63:0] dbus_addr_o, dbus_wdata_o;
  logic [7:0]  dbus_wstrb_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [63:0] dbus_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .rmem_i(rmem_i), .wmem_i(wmem_i), .wb_i(wb_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .result_i(result_i), .rd_idx_i(rd_idx_i), .hold_i(hold_i),
    .raddr_o(raddr_o), .result_o(result_o), .rd_idx_o(rd_idx_o),
    .wb_o(wb_o), .rmem_o(rmem_o), .wmem_o(wmem_o), .hold_o(hold_o),
    .exc_o(exc_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_wstrb_o(dbus_wstrb_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: access size in bytes and aligned byte offset
  function automatic int size_b(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int eff_off(input logic [2:0] f3, input logic [63:0] a);
    int n = size_b(f3);
    int o = int'(a[2:0]);
    return o - (o % n);
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] rd);
    int n = size_b(f3);
    int o = eff_off(f3, a);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [63:0] a);
    int n = size_b(f3);
    int o = eff_off(f3, a);
    logic [7:0] s = '0;
    for (int i = 0; i < n; i++) s[o+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] wd);
    int n = size_b(f3);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; rmem_i = 1'b0; wmem_i = 1'b0; wb_i = 1'b0;
    hold_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
  endtask

  // Non-memory cycle: result must pass straight through with no stall or bus
  task automatic pass_thru(input bit v, input bit rm);
    @(negedge clk);
    idle_inputs();
    valid_i  = v;
    rmem_i   = rm;
    result_i = {$urandom, $urandom};
    #1;
    check_eq("pt_result", result_o, result_i);
    check_eq("pt_hold", 64'(hold_o), 64'd0);
    check_eq("pt_req", 64'(dbus_req_o), 64'd0);
  endtask

  // One load/store: gnt after gd extra REQ cycles, rvalid rdly cycles after
  // gnt, DONE held for hd extra cycles via hold_i.
  task automatic run_op(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] rdat,
                        input int gd, input int rdly, input int hd);
    int last_hold = 2 + gd + rdly;
    int req_cnt = 0;
    int hold_cnt = 0;
    @(negedge clk);
    idle_inputs();
    valid_i  = 1'b1;
    rmem_i   = ld;
    wmem_i   = !ld;
    wb_i     = ld;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wd;
    rd_idx_i = 5'($urandom);
    result_i = {$urandom, $urandom};
    #1;
    check_eq("raddr", raddr_o, addr);
    check_eq("rd_idx", 64'(rd_idx_o), 64'(rd_idx_i));
`ifdef MEM_MISALIGN_TRAP_EN
    if (((int'(addr[2:0])) % size_b(f3)) != 0) begin
      check_eq("trap_exc", 64'(exc_o), 64'd1);
      check_eq("trap_hold", 64'(hold_o), 64'd0);
      check_eq("trap_wb", 64'({wb_o, rmem_o, wmem_o}), 64'd0);
      check_eq("trap_req", 64'(dbus_req_o), 64'd0);
      pass_thru(1'b0, 1'b0);
      return;
    end
`endif
    check_eq("flags", 64'({wb_o, rmem_o, wmem_o, exc_o}), 64'({ld, ld, !ld, 1'b0}));
    for (int k = 0; k <= last_hold; k++) begin
      if (k > 0) begin
        @(negedge clk);
        dbus_gnt_i    = (k == 1 + gd);
        dbus_rvalid_i = (k == last_hold) || (k <= 1 + gd && $urandom_range(0, 1) == 1);
        dbus_rdata_i  = (k == last_hold) ? rdat : {$urandom, $urandom};
        hold_i        = ($urandom_range(0, 1) == 1);
        #1;
      end
      hold_cnt += int'(hold_o);
      req_cnt  += int'(dbus_req_o);
      if (k == 1 + gd) begin
        check_eq("bus_addr", dbus_addr_o, addr & ~64'h7);
        check_eq("bus_we", 64'(dbus_we_o), 64'(!ld));
        if (!ld) begin
          check_eq("bus_wstrb", 64'(dbus_wstrb_o), 64'(model_strb(f3, addr)));
          check_eq("bus_wdata", dbus_wdata_o, model_wdata(f3, wd));
        end
      end
    end
    check_eq("hold_cycles", 64'(hold_cnt), 64'(3 + gd + rdly));
    check_eq("req_cycles", 64'(req_cnt), 64'(1 + gd));
    for (int j = 0; j <= hd; j++) begin
      @(negedge clk);
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      hold_i        = (j < hd);
      #1;
      check_eq("done_hold", 64'(hold_o), 64'd0);
      if (ld) check_eq("load_result", result_o, model_load(f3, addr, rdat));
    end
    pass_thru(1'b0, 1'b0);
  endtask

  bit          r_ld;
  logic [2:0]  r_f3;
  logic [63:0] r_addr;

  initial begin
    idle_inputs();
    rst = 1'b0;
    funct3_i = '0; addr_i = '0; wdata_i = '0; result_i = '0; rd_idx_i = '0;
    dbus_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hold", 64'(hold_o), 64'd0);
    check_eq("rst_req", 64'(dbus_req_o), 64'd0);
    check_eq("rst_we", 64'(dbus_we_o), 64'd0);
    check_eq("rst_wstrb", 64'(dbus_wstrb_o), 64'd0);
    check_eq("rst_exc", 64'(exc_o), 64'd0);
    check_eq("rst_addr", dbus_addr_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    pass_thru(1'b1, 1'b0);
    pass_thru(1'b0, 1'b1);

    run_op(1'b1, 3'b000, 64'h1003, '0, 64'h0000_0000_8000_0000, 0, 0, 0);
    run_op(1'b1, 3'b100, 64'h1003, '0, 64'h0000_0000_8000_0000, 0, 0, 0);
    run_op(1'b0, 3'b001, 64'h2006, 64'hABCD, '0, 0, 0, 0);
    run_op(1'b1, 3'b011, 64'h4000, '0, 64'hDEAD_BEEF_0123_4567, 2, 2, 0);
    run_op(1'b1, 3'b010, 64'h5004, '0, 64'h8765_4321_0000_0000, 0, 1, 3);

    // Reset while a store waits for its acknowledge, then a late rvalid
    @(negedge clk);
    idle_inputs();
    valid_i = 1'b1; wmem_i = 1'b1; funct3_i = 3'b010; addr_i = 64'h6000;
    wdata_i = 64'h1122_3344;
    #1;
    check_eq("rw_hold_idle", 64'(hold_o), 64'd1);
    @(negedge clk);
    dbus_gnt_i = 1'b1;
    #1;
    check_eq("rw_req", 64'(dbus_req_o), 64'd1);
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    #1;
    check_eq("rw_hold_wait", 64'(hold_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rw_rst_hold", 64'(hold_o), 64'd0);
    check_eq("rw_rst_req", 64'(dbus_req_o), 64'd0);
    check_eq("rw_rst_we", 64'(dbus_we_o), 64'd0);
    check_eq("rw_rst_wstrb", 64'(dbus_wstrb_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    dbus_rvalid_i = 1'b1;
    #1;
    check_eq("rw_late_hold", 64'(hold_o), 64'd0);
    pass_thru(1'b0, 1'b0);
    run_op(1'b1, 3'b110, 64'h7008, '0, 64'hFFFF_FFFF_F000_0001, 1, 0, 0);

    // Misaligned word: trapped, or masked down to lane 0
    run_op(1'b1, 3'b010, 64'h3002, '0, 64'hFFFF_FFFF_8765_4321, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r_ld   = ($urandom_range(0, 1) == 1);
      r_f3   = r_ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      r_addr = {$urandom, $urandom};
      run_op(r_ld, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
